mmio_router: RTL and testbench
==============================

// Module: mmio_router
// PURPOSE
//   Parametrised memory-mapped I/O interconnect between the CPU data port and NUM_SLV peripherals.
//   Decodes the region field of each access, forwards it to one slave with a req/ready handshake,
//   returns registered read data, and reports unmapped or timed-out accesses.
//   Failed accesses are recorded in a sticky error register. Sits between cpu and data_mem, LED,
//   HEX, keyboard, timer and VGA slaves.
// PARAMETERS
//   NUM_SLV     8          number of slave channels (1..16)
//   ADDR_W      32         address width
//   DATA_W      32         data width (multiple of 8)
//   REG_MSB     31         region field MSB in address
//   REG_LSB     20         region field LSB in address
//   SLV_BASE    0          packed NUM_SLV x (REG_MSB-REG_LSB+1) region IDs; slice i is the region ID of slave i
//   TIMEOUT     255        max ACCESS cycles before abort; 0 disables the timeout
// PORTS
//   clock     in   1               system clock, all logic on posedge
//   reset     in   1               synchronous, active-low
//   m_req     in   1               master request, held until m_ready
//   m_we      in   1               1=write, 0=read
//   m_addr    in   ADDR_W          master address
//   m_wdata   in   DATA_W          master write data
//   m_wstrb   in   DATA_W/8        byte write enables
//   m_ready   out  1               one-cycle completion pulse
//   m_rdata   out  DATA_W          read data, valid while m_ready=1
//   m_err     out  1               access failed, valid while m_ready=1
//   s_req     out  NUM_SLV         one-hot slave request
//   s_we      out  1               latched m_we
//   s_addr    out  ADDR_W          latched m_addr
//   s_wdata   out  DATA_W          latched m_wdata
//   s_wstrb   out  DATA_W/8        latched m_wstrb
//   s_ready   in   NUM_SLV         per-slave completion
//   s_rdata   in   NUM_SLV*DATA_W  per-slave read data, slice i belongs to slave i
//   err_code  out  2               0=none, 1=INVALID_READ, 2=INVALID_WRITE, 3=TIMEOUT
//   err_addr  out  ADDR_W          address of the first recorded error
//   err_clr   in   1               clears err_code and err_addr
// BEHAVIOUR
//   Reset (reset=0 at a posedge): FSM=IDLE; every output, the latches and the timeout counter go to 0.
//     Reset asserted mid-ACCESS drops s_req at that edge; no m_ready is issued for the aborted access.
//   FSM states: IDLE, ACCESS, RESP.
//   IDLE, m_req=1: latch we/addr/wdata/wstrb and decode region = m_addr[REG_MSB:REG_LSB].
//     Match: slave i = lowest index whose SLV_BASE slice equals region; go to ACCESS.
//     No match: go to RESP with m_err=1; code 1 for a read, 2 for a write.
//   ACCESS: s_req[i]=1, all other s_req bits 0, s_* data outputs stable.
//     s_ready[i]=1: capture s_rdata slice i (reads only; writes capture 0) and go to RESP.
//       s_req drops at the same edge.
//     Otherwise the counter increments. When the counter reaches TIMEOUT-1 without s_ready[i],
//       go to RESP with m_err=1 and code 3.
//     s_ready bits of non-selected slaves are ignored.
//   RESP: m_ready=1 for exactly one cycle; m_rdata=0 whenever m_err=1. Next state is always IDLE.
//   Master protocol: hold m_req until m_ready. m_req seen in IDLE after RESP is a new access,
//     so the master drops m_req the cycle after m_ready.
//   Latency: from m_req sampled to m_ready is 2 cycles minimum (slave ready in its first ACCESS
//     cycle), 1 cycle for an unmapped access.
//   Throughput: at most one access per 3 cycles; no pipelining and no outstanding requests.
//   Error register:
//     Loads code and m_addr only when err_code==0; the first error is sticky.
//     err_clr=1 zeroes both registers.
//     err_clr coincident with a new error: the new error is loaded (error wins).
// TESTING
//   1. SLV_BASE slot2=0x003; read 0x0030_0010, slave2 ready in its first cycle returning
//      0xDEADBEEF -> m_ready 2 cycles after m_req, m_rdata=0xDEADBEEF, m_err=0.
//   2. Write 0x0040_0000, data 0x1234, wstrb 0x3, slave ready after 5 cycles -> s_req held
//      exactly 6 cycles, s_wdata=0x1234 stable, m_rdata=0.
//   3. Read unmapped 0x0FF0_0000 -> m_ready after 1 cycle, m_err=1, err_code=1,
//      err_addr=0x0FF0_0000; a second unmapped write leaves err_code=1.
//   4. TIMEOUT=4, slave never ready -> s_req high 4 cycles, m_err=1, err_code=3;
//      err_clr coincident with a new invalid write -> err_code=2.
//   5. Two slaves share region 0x001 -> only the lower index sees s_req.
//      Drive reset=0 mid-ACCESS -> s_req=0 next edge, m_ready never pulses, err regs=0.

Source files
------------

// File: rtl/mmio_router_if.sv
// mmio_router_if -- bundle of every bus signal around the MMIO router.
//   m_*  : CPU data port (req/ready handshake, one access at a time)
//   s_*  : fan-out to NUM_SLV peripherals (one-hot s_req, shared data lines,
//          per-slave s_ready and packed s_rdata, slice i = slave i)
// Modports:
//   slave  : the router's view (accepts the CPU access, drives the slaves)
//   master : the environment's view (CPU plus peripherals driving the router)
interface mmio_router_if #(
   parameter int NUM_SLV = 8,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32
);
   logic                        m_req;
   logic                        m_we;
   logic [ADDR_W-1:0]           m_addr;
   logic [DATA_W-1:0]           m_wdata;
   logic [DATA_W/8-1:0]         m_wstrb;
   logic                        m_ready;
   logic [DATA_W-1:0]           m_rdata;
   logic                        m_err;
   logic [NUM_SLV-1:0]          s_req;
   logic                        s_we;
   logic [ADDR_W-1:0]           s_addr;
   logic [DATA_W-1:0]           s_wdata;
   logic [DATA_W/8-1:0]         s_wstrb;
   logic [NUM_SLV-1:0]          s_ready;
   logic [NUM_SLV*DATA_W-1:0]   s_rdata;

   modport slave (
      input  m_req, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
      output m_ready, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, s_wstrb
   );

   modport master (
      output m_req, m_we, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
      input  m_ready, m_rdata, m_err, s_req, s_we, s_addr, s_wdata, s_wstrb
   );
endinterface

// File: rtl/mmio_router.sv
// mmio_router -- MMIO interconnect between the CPU data port and NUM_SLV
// peripherals. Decodes addr[REG_MSB:REG_LSB] against per-slave region IDs,
// forwards the access to the lowest matching slave, returns registered read
// data and flags unmapped or timed-out accesses.
// Ports:
//   clock    : system clock, posedge
//   reset    : synchronous, active-low
//   bus      : mmio_router_if.slave (CPU m_* side and slave s_* side)
//   err_code : sticky error code (0 none, 1 bad read, 2 bad write, 3 timeout)
//   err_addr : address of the first recorded error
//   err_clr  : clears err_code/err_addr (a coincident new error still loads)

// Region compare for one slave channel.
module mmio_router_match #(
   parameter int RW = 12
) (
   input  logic [RW-1:0] region,
   input  logic [RW-1:0] base,
   output logic          hit
);
   assign hit = (region == base);
endmodule

module mmio_router #(
   parameter int NUM_SLV = 8,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int REG_MSB = 31,
   parameter int REG_LSB = 20,
   parameter logic [NUM_SLV*(REG_MSB-REG_LSB+1)-1:0] SLV_BASE = '0,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              reset,
   mmio_router_if.slave      bus,
   output logic [1:0]        err_code,
   output logic [ADDR_W-1:0] err_addr,
   input  logic              err_clr
);
   localparam int RW     = REG_MSB - REG_LSB + 1;
   localparam int STRB_W = DATA_W / 8;
   localparam int SEL_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] E_RD = 2'd1;
   localparam logic [1:0] E_WR = 2'd2;
   localparam logic [1:0] E_TO = 2'd3;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   state_t             state;
   req_t               req_q;
   logic [SEL_W-1:0]   sel;
   logic [CNT_W-1:0]   cnt;
   logic [NUM_SLV-1:0] s_req_q;
   logic               m_ready_q;
   logic               m_err_q;
   logic [DATA_W-1:0]  m_rdata_q;

   // ---------------- region decode ----------------
   logic [RW-1:0]      region;
   logic [NUM_SLV-1:0] hit;
   logic [SEL_W-1:0]   hit_idx;
   logic               any_hit;

   assign region = bus.m_addr[REG_MSB:REG_LSB];

   for (genvar i = 0; i < NUM_SLV; i++) begin : g_match
      mmio_router_match #(.RW(RW)) u_match (
         .region (region),
         .base   (SLV_BASE[i*RW +: RW]),
         .hit    (hit[i])
      );
   end

   // Scan downward so the lowest matching index wins on shared regions.
   always_comb begin
      hit_idx = '0;
      any_hit = |hit;
      for (int i = NUM_SLV - 1; i >= 0; i--) begin
         if (hit[i]) hit_idx = SEL_W'(i);
      end
   end

   // ---------------- selected slave / error event ----------------
   logic              sel_ready;
   logic [DATA_W-1:0] sel_rdata;
   logic              to_hit;
   logic              new_err;
   logic [1:0]        new_code;
   logic [ADDR_W-1:0] new_addr;

   assign sel_ready = bus.s_ready[sel];
   assign sel_rdata = bus.s_rdata[int'(sel)*DATA_W +: DATA_W];
   assign to_hit    = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      new_err  = 1'b0;
      new_code = 2'd0;
      new_addr = req_q.addr;
      if (state == IDLE && bus.m_req && !any_hit) begin
         new_err  = 1'b1;
         new_code = bus.m_we ? E_WR : E_RD;
         new_addr = bus.m_addr;
      end else if (state == ACCESS && !sel_ready && to_hit) begin
         new_err  = 1'b1;
         new_code = E_TO;
      end
   end

   // ---------------- FSM, datapath and error register ----------------
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         req_q     <= '0;
         sel       <= '0;
         cnt       <= '0;
         s_req_q   <= '0;
         m_ready_q <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
         err_code  <= 2'd0;
         err_addr  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.m_req) begin
                  req_q <= '{we: bus.m_we, addr: bus.m_addr,
                             wdata: bus.m_wdata, wstrb: bus.m_wstrb};
                  cnt   <= '0;
                  if (any_hit) begin
                     sel     <= hit_idx;
                     s_req_q <= NUM_SLV'(1) << hit_idx;
                     state   <= ACCESS;
                  end else begin
                     m_ready_q <= 1'b1;
                     m_err_q   <= 1'b1;
                     m_rdata_q <= '0;
                     state     <= RESP;
                  end
               end
            end
            ACCESS: begin
               if (sel_ready) begin
                  s_req_q   <= '0;
                  m_ready_q <= 1'b1;
                  m_err_q   <= 1'b0;
                  m_rdata_q <= req_q.we ? '0 : sel_rdata;
                  state     <= RESP;
               end else if (to_hit) begin
                  s_req_q   <= '0;
                  m_ready_q <= 1'b1;
                  m_err_q   <= 1'b1;
                  m_rdata_q <= '0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               m_ready_q <= 1'b0;
               m_err_q   <= 1'b0;
               m_rdata_q <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // First error is sticky; a clear in the same cycle as a new error
         // lets the new error through.
         if (new_err && (err_code == 2'd0 || err_clr)) begin
            err_code <= new_code;
            err_addr <= new_addr;
         end else if (err_clr) begin
            err_code <= 2'd0;
            err_addr <= '0;
         end
      end
   end

   assign bus.m_ready = m_ready_q;
   assign bus.m_err   = m_err_q;
   assign bus.m_rdata = m_rdata_q;
   assign bus.s_req   = s_req_q;
   assign bus.s_we    = req_q.we;
   assign bus.s_addr  = req_q.addr;
   assign bus.s_wdata = req_q.wdata;
   assign bus.s_wstrb = req_q.wstrb;
endmodule

// File: tb/tb_mmio_router.sv
// tb_mmio_router -- directed test of mmio_router. Two instances share all
// stimulus: dut (TIMEOUT=255) for normal traffic and dut_to (TIMEOUT=4) for
// the timeout / error-clear scenario. Inputs change and outputs are sampled
// on the falling edge.
module tb_mmio_router;
   localparam int NS = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   // slot: 7=0x007 6=0x006 5=0x001 4=0x005 3=0x004 2=0x003 1=0x001 0=0x100
   localparam logic [NS*12-1:0] BASE = 96'h007006001005004003001100;

   logic clock = 1'b0;
   logic reset;
   logic err_clr;
   logic [1:0]    err_code, err_code2;
   logic [AW-1:0] err_addr, err_addr2;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   mmio_router_if #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();
   mmio_router_if #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW)) bus2 ();

   assign bus2.m_req   = bus.m_req;
   assign bus2.m_we    = bus.m_we;
   assign bus2.m_addr  = bus.m_addr;
   assign bus2.m_wdata = bus.m_wdata;
   assign bus2.m_wstrb = bus.m_wstrb;
   assign bus2.s_ready = bus.s_ready;
   assign bus2.s_rdata = bus.s_rdata;

   mmio_router #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .REG_MSB(31), .REG_LSB(20),
                 .SLV_BASE(BASE), .TIMEOUT(255)) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .err_code(err_code), .err_addr(err_addr), .err_clr(err_clr));

   mmio_router #(.NUM_SLV(NS), .ADDR_W(AW), .DATA_W(DW), .REG_MSB(31), .REG_LSB(20),
                 .SLV_BASE(BASE), .TIMEOUT(4)) dut_to (
      .clock(clock), .reset(reset), .bus(bus2),
      .err_code(err_code2), .err_addr(err_addr2), .err_clr(err_clr));

   task automatic idle_inputs();
      bus.m_req   = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_wstrb = '0;
      bus.s_ready = '0;
      err_clr     = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      bus.s_rdata = '0;
      repeat (3) @(negedge clock);
      tests++;
      if (bus.m_ready !== 1'b0 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_m: ready=%b err=%b rdata=%h required 0/0/0",
                  bus.m_ready, bus.m_err, bus.m_rdata);
      end
      tests++;
      if (bus.s_req !== 8'h00 || bus.s_addr !== 32'h0 || bus.s_we !== 1'b0) begin
         fails++;
         $display("FAIL reset_s: s_req=%h s_addr=%h s_we=%b required 0", bus.s_req, bus.s_addr, bus.s_we);
      end
      tests++;
      if (err_code !== 2'd0 || err_addr !== 32'h0) begin
         fails++;
         $display("FAIL reset_err: code=%0d addr=%h required 0/0", err_code, err_addr);
      end
      reset = 1'b1;
   endtask

   task automatic test_read_fast();
      @(negedge clock);
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 32'h0030_0010;
      bus.s_rdata[2*DW +: DW] = 32'hDEAD_BEEF;
      @(negedge clock);
      tests++;
      if (bus.s_req !== 8'h04 || bus.m_ready !== 1'b0) begin
         fails++;
         $display("FAIL rd_access: s_req=%h m_ready=%b required 04/0", bus.s_req, bus.m_ready);
      end
      bus.s_ready[2] = 1'b1;
      @(negedge clock);
      tests++;
      if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b0 || bus.m_rdata !== 32'hDEAD_BEEF) begin
         fails++;
         $display("FAIL rd_resp: ready=%b err=%b rdata=%h required 1/0/deadbeef",
                  bus.m_ready, bus.m_err, bus.m_rdata);
      end
      tests++;
      if (bus.s_req !== 8'h00) begin
         fails++;
         $display("FAIL rd_sreq_drop: s_req=%h required 00", bus.s_req);
      end
      bus.m_req = 1'b0;
      bus.s_ready = '0;
      @(negedge clock);
      tests++;
      if (bus.m_ready !== 1'b0 || bus.m_rdata !== 32'h0) begin
         fails++;
         $display("FAIL rd_pulse: ready=%b rdata=%h required 0/0", bus.m_ready, bus.m_rdata);
      end
   endtask

   task automatic test_write_slow();
      int cnt = 0;
      bit done = 0;
      bit wd_bad = 0;
      @(negedge clock);
      bus.m_req   = 1'b1;
      bus.m_we    = 1'b1;
      bus.m_addr  = 32'h0040_0000;
      bus.m_wdata = 32'h0000_1234;
      bus.m_wstrb = 4'h3;
      bus.s_rdata[3*DW +: DW] = 32'hCAFE_F00D;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clock);
         if (bus.m_ready === 1'b1) done = 1;
         else begin
            if (bus.s_req[3] === 1'b1) cnt++;
            if (bus.s_wdata !== 32'h0000_1234 || bus.s_wstrb !== 4'h3 || bus.s_we !== 1'b1) wd_bad = 1;
            bus.s_ready[3] = (cnt == 6);
         end
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL wr_timeout: m_ready not seen within 20 cycles, required pulse");
      end
      tests++;
      if (cnt != 6) begin
         fails++;
         $display("FAIL wr_sreq_len: s_req cycles=%0d required 6", cnt);
      end
      tests++;
      if (wd_bad) begin
         fails++;
         $display("FAIL wr_stable: s_wdata/s_wstrb/s_we changed, required 1234/3/1 stable");
      end
      tests++;
      if (bus.m_rdata !== 32'h0 || bus.m_err !== 1'b0 || bus.s_addr !== 32'h0040_0000) begin
         fails++;
         $display("FAIL wr_resp: rdata=%h err=%b s_addr=%h required 0/0/00400000",
                  bus.m_rdata, bus.m_err, bus.s_addr);
      end
      bus.m_req = 1'b0;
      bus.s_ready = '0;
   endtask

   task automatic test_unmapped();
      @(negedge clock);
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 32'h0FF0_0000;
      @(negedge clock);
      tests++;
      if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1 || bus.m_rdata !== 32'h0) begin
         fails++;
         $display("FAIL unm_rd_resp: ready=%b err=%b rdata=%h required 1/1/0",
                  bus.m_ready, bus.m_err, bus.m_rdata);
      end
      tests++;
      if (err_code !== 2'd1 || err_addr !== 32'h0FF0_0000) begin
         fails++;
         $display("FAIL unm_rd_reg: code=%0d addr=%h required 1/0ff00000", err_code, err_addr);
      end
      bus.m_req = 1'b0;
      @(negedge clock);
      tests++;
      if (bus.m_ready !== 1'b0) begin
         fails++;
         $display("FAIL unm_pulse: ready=%b required 0", bus.m_ready);
      end
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b1;
      bus.m_addr = 32'h0FF0_0004;
      @(negedge clock);
      tests++;
      if (bus.m_ready !== 1'b1 || bus.m_err !== 1'b1) begin
         fails++;
         $display("FAIL unm_wr_resp: ready=%b err=%b required 1/1", bus.m_ready, bus.m_err);
      end
      tests++;
      if (err_code !== 2'd1 || err_addr !== 32'h0FF0_0000) begin
         fails++;
         $display("FAIL unm_sticky: code=%0d addr=%h required 1/0ff00000", err_code, err_addr);
      end
      bus.m_req = 1'b0;
   endtask

   task automatic test_timeout();
      int cnt = 0;
      bit done = 0;
      do_reset();
      @(negedge clock);
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 32'h0050_0000;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clock);
         if (bus2.m_ready === 1'b1) done = 1;
         else if (bus2.s_req[4] === 1'b1) cnt++;
      end
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL to_wait: m_ready not seen within 20 cycles, required pulse");
      end
      tests++;
      if (cnt != 4) begin
         fails++;
         $display("FAIL to_sreq_len: s_req cycles=%0d required 4", cnt);
      end
      tests++;
      if (bus2.m_err !== 1'b1 || err_code2 !== 2'd3 || err_addr2 !== 32'h0050_0000 || bus2.s_req !== 8'h00) begin
         fails++;
         $display("FAIL to_resp: err=%b code=%0d addr=%h s_req=%h required 1/3/00500000/00",
                  bus2.m_err, err_code2, err_addr2, bus2.s_req);
      end
      bus.m_req = 1'b0;
      @(negedge clock);
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b1;
      bus.m_addr = 32'h0FF0_0008;
      err_clr    = 1'b1;
      @(negedge clock);
      tests++;
      if (err_code2 !== 2'd2 || err_addr2 !== 32'h0FF0_0008 || bus2.m_ready !== 1'b1) begin
         fails++;
         $display("FAIL clr_vs_err: code=%0d addr=%h ready=%b required 2/0ff00008/1",
                  err_code2, err_addr2, bus2.m_ready);
      end
      bus.m_req = 1'b0;
      err_clr   = 1'b0;
      @(negedge clock);
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      tests++;
      if (err_code2 !== 2'd0 || err_addr2 !== 32'h0) begin
         fails++;
         $display("FAIL clr_only: code=%0d addr=%h required 0/0", err_code2, err_addr2);
      end
   endtask

   task automatic test_shared_and_reset();
      bit pulsed = 0;
      do_reset();
      // leave an error recorded so the mid-access reset has something to clear
      @(negedge clock);
      bus.m_req  = 1'b1;
      bus.m_we   = 1'b0;
      bus.m_addr = 32'h0FF0_0000;
      @(negedge clock);
      bus.m_req = 1'b0;
      @(negedge clock);
      bus.m_req  = 1'b1;
      bus.m_addr = 32'h0010_0000;
      bus.s_ready[5] = 1'b1;
      @(negedge clock);
      tests++;
      if (bus.s_req !== 8'h02) begin
         fails++;
         $display("FAIL shared_sel: s_req=%h required 02", bus.s_req);
      end
      @(negedge clock);
      tests++;
      if (bus.s_req !== 8'h02 || bus.m_ready !== 1'b0 || err_code !== 2'd1) begin
         fails++;
         $display("FAIL shared_ignore: s_req=%h ready=%b code=%0d required 02/0/1",
                  bus.s_req, bus.m_ready, err_code);
      end
      reset = 1'b0;
      @(negedge clock);
      tests++;
      if (bus.s_req !== 8'h00 || err_code !== 2'd0 || err_addr !== 32'h0) begin
         fails++;
         $display("FAIL mid_reset: s_req=%h code=%0d addr=%h required 00/0/0",
                  bus.s_req, err_code, err_addr);
      end
      reset = 1'b1;
      bus.m_req = 1'b0;
      bus.s_ready = '0;
      if (bus.m_ready === 1'b1) pulsed = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clock);
         if (bus.m_ready !== 1'b0) pulsed = 1;
      end
      tests++;
      if (pulsed) begin
         fails++;
         $display("FAIL mid_reset_ready: m_ready pulsed after aborted access, required none");
      end
   endtask

   initial begin
      test_reset();
      test_read_fast();
      test_write_slow();
      test_unmapped();
      test_timeout();
      test_shared_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
